hash_partitioner: RTL and testbench

//  Downstream companion of the MurMur hasher. Accepts a valid/ready key stream, drives the hasher
//  (key out, stall-enable out, hash in) and re-aligns each key with its hash via a matched delay line.

---
 rtl/hash_partitioner.sv | 142 ++++++++++++++
 tb/tb_hash_partitioner.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_partitioner.sv
// Purpose : re-aligns keys with their MurMur hash, tags a partition id and batch-last flag.
// Latency : HASH_LATENCY+1 cycles from s_valid&s_ready to m_valid when not stalled.
// Backpres: the whole pipe (hasher included) freezes while m_valid & ~m_ready; s_ready drops.
//
// Ports: s_key/s_valid/s_ready   input key stream
//        o_hash_key/o_hash_en    drive the external hasher; i_hash returns its result
//        m_key/m_hash/m_part/m_last/m_valid/m_ready   output tuple stream
//        i_flush/o_flush_done    close the current batch early / completion pulse
//        stat_addr/stat_count    per-partition handshake counters (HASH_PART_STATS_EN)
// Optional feature macro: HASH_PART_STATS_EN (per-partition counters; otherwise stat_count = 0).
module hash_partitioner #(
    parameter int KEY_WIDTH    = 32,
    parameter int HASH_WIDTH   = 32,
    parameter int HASH_LATENCY = 6,
    parameter int PART_BITS    = 4,
    parameter int BATCH_SIZE   = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [KEY_WIDTH-1:0]  s_key,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [KEY_WIDTH-1:0]  o_hash_key,
    output logic                  o_hash_en,
    input  logic [HASH_WIDTH-1:0] i_hash,
    output logic [KEY_WIDTH-1:0]  m_key,
    output logic [HASH_WIDTH-1:0] m_hash,
    output logic [PART_BITS-1:0]  m_part,
    output logic                  m_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    input  logic                  i_flush,
    output logic                  o_flush_done,
    input  logic [PART_BITS-1:0]  stat_addr,
    output logic [31:0]           stat_count
);
    localparam int NUM_PART = 2 ** PART_BITS;
    localparam int CNT_W    = (BATCH_SIZE > 1) ? $clog2(BATCH_SIZE) : 1;
    localparam logic [HASH_LATENCY-1:0] TAIL_MASK = HASH_LATENCY'(1) << (HASH_LATENCY - 1);

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t                 state, state_nxt;
    logic [KEY_WIDTH-1:0]   dl_key [HASH_LATENCY];
    logic [HASH_LATENCY-1:0] dl_vld;
    logic [CNT_W-1:0]       batch_cnt;

    logic adv, accept, tail_vld, behind_vld, pipe_busy;
    logic closing, cnt_last, flush_last, mark_held;

    // The hasher and the delay line advance in lockstep so key and hash stay aligned.
    assign adv        = ~m_valid | m_ready;
    assign o_hash_en  = adv & rst_n;
    assign s_ready    = adv & (state == RUN) & rst_n;
    assign o_hash_key = s_key;
    assign accept     = s_valid & s_ready;
    assign tail_vld   = dl_vld[HASH_LATENCY-1];

    // Anything still queued behind the tail (including a key entering this cycle).
    assign behind_vld = accept | (|(dl_vld & ~TAIL_MASK));
    assign pipe_busy  = accept | (|dl_vld) | (m_valid & ~m_ready);

    assign closing    = (state == DRAIN) | ((state == RUN) & i_flush);
    assign cnt_last   = (batch_cnt == CNT_W'(BATCH_SIZE - 1));
    assign flush_last = closing & ~behind_vld;
    // Flush arrives while the final tuple is already parked in the output register:
    // it cannot be reloaded, so its last flag is raised in place.
    assign mark_held  = (state == RUN) & i_flush & m_valid & ~m_ready & ~(|dl_vld);

    always_comb begin
        state_nxt    = state;
        o_flush_done = 1'b0;
        unique case (state)
            RUN:     if (i_flush) state_nxt = pipe_busy ? DRAIN : DONE;
            DRAIN:   if (~(|dl_vld) & adv) state_nxt = DONE;
            DONE: begin
                o_flush_done = 1'b1;
                state_nxt    = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            dl_vld    <= '0;
            batch_cnt <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            m_key     <= '0;
            m_hash    <= '0;
            m_part    <= '0;
        end else begin
            state <= state_nxt;
            if (adv) begin
                dl_vld[0] <= accept;
                for (int i = 1; i < HASH_LATENCY; i++) dl_vld[i] <= dl_vld[i-1];
                m_valid <= tail_vld;
                m_key   <= dl_key[HASH_LATENCY-1];
                m_hash  <= i_hash;
                m_part  <= i_hash[HASH_WIDTH-1 -: PART_BITS];
                m_last  <= tail_vld & (cnt_last | flush_last);
            end else if (mark_held) begin
                m_last <= 1'b1;
            end
            if (state == DONE) batch_cnt <= '0;
            else if (adv & tail_vld) batch_cnt <= cnt_last ? '0 : batch_cnt + 1'b1;
        end
    end

    // Key payload needs no reset: its valid bit travels alongside.
    always_ff @(posedge clk) begin
        if (adv) begin
            dl_key[0] <= s_key;
            for (int i = 1; i < HASH_LATENCY; i++) dl_key[i] <= dl_key[i-1];
        end
    end

`ifdef HASH_PART_STATS_EN
    logic [31:0] part_cnt [NUM_PART];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PART; i++) part_cnt[i] <= '0;
            stat_count <= '0;
        end else begin
            for (int i = 0; i < NUM_PART; i++) begin
                if (state == DONE) part_cnt[i] <= '0;
                else if (m_valid & m_ready & (m_part == PART_BITS'(i)) & (part_cnt[i] != 32'hFFFF_FFFF))
                    part_cnt[i] <= part_cnt[i] + 32'd1;
            end
            stat_count <= part_cnt[stat_addr];
        end
    end
`else
    logic unused_stat_addr;
    assign unused_stat_addr = ^stat_addr;
    assign stat_count       = '0;
`endif

endmodule

// File: tb/tb_hash_partitioner.sv
module tb_hash_partitioner;
    localparam int KW = 32, HW = 32, HL = 6, PB = 4, BS = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [KW-1:0] s_key = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [KW-1:0] o_hash_key;
    logic          o_hash_en;
    logic [HW-1:0] i_hash;
    logic [KW-1:0] m_key;
    logic [HW-1:0] m_hash;
    logic [PB-1:0] m_part;
    logic          m_last, m_valid;
    logic          m_ready = 1'b0;
    logic          i_flush = 1'b0;
    logic          o_flush_done;
    logic [PB-1:0] stat_addr = '0;
    logic [31:0]   stat_count;

    always #5 clk = ~clk;

    hash_partitioner #(.KEY_WIDTH(KW), .HASH_WIDTH(HW), .HASH_LATENCY(HL),
                       .PART_BITS(PB), .BATCH_SIZE(BS)) dut (
        .clk(clk), .rst_n(rst_n), .s_key(s_key), .s_valid(s_valid), .s_ready(s_ready),
        .o_hash_key(o_hash_key), .o_hash_en(o_hash_en), .i_hash(i_hash),
        .m_key(m_key), .m_hash(m_hash), .m_part(m_part), .m_last(m_last),
        .m_valid(m_valid), .m_ready(m_ready), .i_flush(i_flush), .o_flush_done(o_flush_done),
        .stat_addr(stat_addr), .stat_count(stat_count)
    );

    function automatic logic [31:0] fmix32(input logic [31:0] k);
        logic [31:0] h;
        h = k;
        h = h ^ (h >> 16);
        h = h * 32'h85eb_ca6b;
        h = h ^ (h >> 13);
        h = h * 32'hc2b2_ae35;
        h = h ^ (h >> 16);
        return h;
    endfunction

    // Stand-in MurMur hasher: HL enabled register stages, fmix32 on the way out.
    logic [31:0] hp [HL];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < HL; i++) hp[i] <= '0;
        end else if (o_hash_en) begin
            hp[0] <= o_hash_key;
            for (int i = 1; i < HL; i++) hp[i] <= hp[i-1];
        end
    end
    assign i_hash = fmix32(hp[HL-1]);

    // Reference model: ordered tuple queue with batch bookkeeping.
    typedef struct {
        logic [31:0] key;
        logic        last;
        int          acc;
    } exp_t;

    exp_t        expq [$];
    int          checks = 0, errors = 0, cyc = 0, bn = 0;
    bit          pending = 0, exp_done = 0, hold = 0, chk_lat = 0;
    logic [31:0] hold_key, hold_hash;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic sv, input logic [31:0] k, input logic mr, input logic fl,
                         output bit acc);
        exp_t        e;
        logic [31:0] h;
        bit          nd;
        s_valid = sv; s_key = k; m_ready = mr; i_flush = fl;
        #1;
        chk("flush_done", o_flush_done, exp_done);
        if (m_valid && !m_ready) chk("s_ready_stall", s_ready, 0);
        if (pending || exp_done) chk("s_ready_flush", s_ready, 0);
        if (hold) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_key", m_key, hold_key);
            chk("hold_hash", m_hash, hold_hash);
        end
        if (m_valid && m_ready) begin
            if (expq.size() == 0) chk("spurious_out", m_valid, 0);
            else begin
                e = expq.pop_front();
                h = fmix32(e.key);
                chk("out_key", m_key, e.key);
                chk("out_hash", m_hash, h);
                chk("out_part", m_part, h[31:28]);
                chk("out_last", m_last, e.last);
                if (chk_lat) chk("latency", cyc - e.acc, HL + 1);
            end
        end
        acc = s_valid && s_ready;
        if (acc) begin
            e.key = k; e.last = 1'b0; e.acc = cyc;
            bn++;
            if (bn == BS) begin e.last = 1'b1; bn = 0; end
            expq.push_back(e);
        end
        if (fl && !pending && !exp_done) begin
            if (expq.size() > 0) expq[expq.size()-1].last = 1'b1;
            bn = 0;
            pending = 1;
        end
        nd = 0;
        if (pending && expq.size() == 0) begin nd = 1; pending = 0; end
        hold = m_valid && !m_ready;
        hold_key = m_key;
        hold_hash = m_hash;
        @(posedge clk); #1;
        cyc++;
        exp_done = nd;
    endtask

    function automatic logic rnd_ready(input bit rnd);
        return rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    endfunction

    task automatic send(input logic [31:0] k, input bit rnd);
        bit a = 0;
        int n = 0;
        while (!a && n < 100) begin
            cycle(1'b1, k, rnd_ready(rnd), 1'b0, a);
            n++;
        end
        chk("send_accepted", a, 1);
    endtask

    task automatic drain(input bit rnd);
        bit a;
        int n = 0;
        while ((expq.size() != 0 || pending || exp_done) && n < 300) begin
            cycle(1'b0, 32'h0, rnd_ready(rnd), 1'b0, a);
            n++;
        end
        chk("drain_complete", (expq.size() != 0) || pending || exp_done, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          a;
        logic [31:0] k, h;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_flush_done", o_flush_done, 0);
        chk("rst_m_key", m_key, 0);
        chk("rst_m_hash", m_hash, 0);
        chk("rst_m_part", m_part, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_hash_en", o_hash_en, 0);
        chk("rst_stat_count", stat_count, 0);
        rst_n = 1'b1;
        #1;
        chk("idle_s_ready", s_ready, 1);
        chk("idle_hash_en", o_hash_en, 1);
        @(posedge clk); #1;

        // 1: key 0, no stall, latency HL+1
        chk_lat = 1;
        send(32'h0, 0);
        drain(0);
        chk_lat = 0;

        // 2: 20 random keys with random output backpressure and input bubbles
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 3) == 0) cycle(1'b0, 32'h0, rnd_ready(1), 1'b0, a);
            k = $urandom;
            s_key = k; #0;
            chk("hash_key_passthru", o_hash_key, k);
            send(k, 1);
        end
        drain(1);

        // Close the partial batch so the count-based test starts clean
        cycle(1'b0, 32'h0, 1'b1, 1'b1, a);
        drain(0);

        // 3: 8 back-to-back keys close a batch, 9th starts the next
        for (int i = 0; i < BS + 1; i++) send($urandom, 0);
        drain(0);

        // 4: 3 keys in flight, then flush with random backpressure
        cycle(1'b0, 32'h0, 1'b1, 1'b1, a);
        drain(0);
        for (int i = 0; i < 3; i++) send($urandom, 0);
        cycle(1'b0, 32'h0, 1'b1, 1'b1, a);
        drain(1);

        // Flush with a key handshaking in the same cycle
        send($urandom, 0);
        cycle(1'b1, $urandom, 1'b1, 1'b1, a);
        drain(1);

        // 5: flush on an idle block
        cycle(1'b0, 32'h0, 1'b1, 1'b1, a);
        chk("idle_flush_pending", exp_done, 1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, a);
        chk("idle_flush_no_out", m_valid, 0);

        // Reset with 4 tuples in flight
        for (int i = 0; i < 4; i++) send($urandom, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_s_ready", s_ready, 0);
        chk("midrst_hash_en", o_hash_en, 0);
        chk("midrst_m_valid", m_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        expq.delete();
        bn = 0; pending = 0; exp_done = 0; hold = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 32'h0, 1'b1, 1'b0, a);
            chk("postrst_no_out", m_valid, 0);
        end

`ifdef HASH_PART_STATS_EN
        // 6: five keys hashed into partition 5
        for (int i = 0; i < 5; i++) begin
            k = $urandom;
            for (int t = 0; t < 10000; t++) begin
                h = fmix32(k);
                if (h[31:28] == 4'h5) break;
                k = $urandom;
            end
            send(k, 0);
        end
        drain(0);
        for (int adr = 0; adr < (1 << PB); adr++) begin
            stat_addr = PB'(adr);
            cycle(1'b0, 32'h0, 1'b1, 1'b0, a);
            chk("stat_count", stat_count, (adr == 5) ? 5 : 0);
        end
        cycle(1'b0, 32'h0, 1'b1, 1'b1, a);
        drain(0);
        stat_addr = 4'h5;
        cycle(1'b0, 32'h0, 1'b1, 1'b0, a);
        chk("stat_cleared", stat_count, 0);
`else
        for (int i = 0; i < 3; i++) send($urandom, 0);
        drain(0);
        for (int adr = 0; adr < (1 << PB); adr += 5) begin
            stat_addr = PB'(adr);
            cycle(1'b0, 32'h0, 1'b1, 1'b0, a);
            chk("stat_disabled", stat_count, 0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
